// File: rtl/shift_sequencer.sv
// shift_sequencer: sequenced serial shifter with a start/busy/done handshake.
// Captures an operand, a shift distance and an op code, then performs one
// 1-bit shift per clock. The result register is loaded only on entry to DONE.
// Optional build macro: SHIFT_ROTATE_EN (op=11 rotates right; otherwise SRL).
module shift_sequencer #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] din,
    input  logic [AMT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   sr_reg, sr_next;
    logic [AMT_W-1:0]   cnt_reg, cnt_next;
    logic [1:0]         op_reg, op_next;
    logic [WIDTH-1:0]   result_reg, result_next;

    logic [WIDTH-1:0]   shl_val;
    logic [WIDTH-1:0]   shr_val;
    logic               shr_fill;
    logic [WIDTH-1:0]   shift_val;

    // One-bit neighbour wiring for left and right shifts.
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_neigh
            assign shl_val[gi+1] = sr_reg[gi];
            assign shr_val[gi]   = sr_reg[gi+1];
        end
    endgenerate
    assign shl_val[0]       = 1'b0;
    assign shr_val[WIDTH-1] = shr_fill;

    // Fill bit entering at the MSB for right-going ops.
    always_comb begin
        shr_fill = 1'b0;
        case (op_reg)
            OP_SRA:  shr_fill = sr_reg[WIDTH-1];
`ifdef SHIFT_ROTATE_EN
            2'b11:   shr_fill = sr_reg[0];
`endif
            default: shr_fill = 1'b0;
        endcase
    end

    // Select the direction of the single-bit step.
    always_comb begin
        shift_val = (op_reg == OP_SLL) ? shl_val : shr_val;
    end

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_next  = state_reg;
        sr_next     = sr_reg;
        cnt_next    = cnt_reg;
        op_next     = op_reg;
        result_next = result_reg;
        busy        = 1'b0;
        done        = 1'b0;
        case (state_reg)
            SHIFT: begin
                busy     = 1'b1;
                sr_next  = shift_val;
                cnt_next = cnt_reg - AMT_W'(1);
                if (cnt_reg == AMT_W'(1)) begin
                    state_next  = DONE;
                    result_next = shift_val;
                end
            end
            IDLE, DONE: begin
                done = (state_reg == DONE);
                if (start) begin
                    sr_next  = din;
                    cnt_next = amount;
                    op_next  = op;
                    if (amount == '0) begin
                        // Zero distance: result is the operand itself.
                        state_next  = DONE;
                        result_next = din;
                    end else begin
                        state_next = SHIFT;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            sr_reg     <= '0;
            cnt_reg    <= '0;
            op_reg     <= '0;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            sr_reg     <= sr_next;
            cnt_reg    <= cnt_next;
            op_reg     <= op_next;
            result_reg <= result_next;
        end
    end

    assign result = result_reg;

endmodule

// File: tb/tb_shift_sequencer.sv
// Testbench for shift_sequencer: table-driven vectors, hand-written handshake
// and reset sequences, and randomized operations against an arithmetic model.
module tb_shift_sequencer;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] din;
    logic [4:0]  amount;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int pass_cnt  = 0;
    int total_cnt = 0;

    shift_sequencer #(.WIDTH(32), .AMT_W(5)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .din    (din),
        .amount (amount),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] din;
        logic [4:0]  amt;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Reference: the whole multi-bit shift in one arithmetic step.
    function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] d, input logic [4:0] a);
        logic [31:0] r;
        int sh;
        sh = int'(a);
        case (o)
            2'b00: r = d << sh;
            2'b01: r = d >> sh;
            2'b10: r = $unsigned($signed(d) >>> sh);
`ifdef SHIFT_ROTATE_EN
            default: r = (d >> sh) | (d << (32 - sh));
`else
            default: r = d >> sh;
`endif
        endcase
        return r;
    endfunction

    // Issue one op from IDLE or DONE and wait (bounded) for its done pulse.
    // Latency counts cycles from the capture edge to the done cycle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] d, input logic [4:0] a,
                          input bit noise, output logic [31:0] res, output int lat,
                          output logic busy_at_done);
        op = o; din = d; amount = a; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            if (noise) begin
                din    = $urandom;
                op     = 2'($urandom);
                amount = 5'($urandom);
                start  = 1'($urandom_range(0, 1));
            end
            @(posedge clock); #1;
            lat++;
        end
        start = 1'b0;
        res = result;
        busy_at_done = busy;
    endtask

    initial begin
        logic [31:0] res;
        int          lat;
        logic        bad;
        int          dones;
        logic [1:0]  ro;
        logic [31:0] rd;
        logic [4:0]  ra;

        vecs[0] = '{2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1};
        vecs[1] = '{2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 32};
        vecs[2] = '{2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000, 5};
        vecs[3] = '{2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000, 5};
`ifdef SHIFT_ROTATE_EN
        vecs[4] = '{2'b11, 32'h0000_0001, 5'd1,  32'h8000_0000, 2};
        vecs[5] = '{2'b11, 32'h1234_5678, 5'd4,  32'h8123_4567, 5};
`else
        vecs[4] = '{2'b11, 32'h0000_0001, 5'd1,  32'h0000_0000, 2};
        vecs[5] = '{2'b11, 32'h1234_5678, 5'd4,  32'h0123_4567, 5};
`endif
        vecs[6] = '{2'b10, 32'h4000_0000, 5'd5,  32'h0200_0000, 6};
        vecs[7] = '{2'b10, 32'h8000_0001, 5'd31, 32'hFFFF_FFFF, 32};
        vecs[8] = '{2'b01, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001, 32};
        vecs[9] = '{2'b00, 32'hA5A5_A5A5, 5'd8,  32'hA5A5_A500, 9};

        reset = 1'b1; start = 1'b0; op = '0; din = '0; amount = '0;
        #1;
        chk("reset_busy",   32'(busy),   32'h0);
        chk("reset_done",   32'(done),   32'h0);
        chk("reset_result", result,      32'h0);
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        @(posedge clock); #1;

        // Table vectors, issued back-to-back (each start lands in the DONE cycle).
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].din, vecs[i].amt, 1'b0, res, lat, bad);
            $display("vec %0d op=%0d din=%08h amt=%0d -> result=%08h lat=%0d",
                     i, vecs[i].op, vecs[i].din, vecs[i].amt, res, lat);
            chk($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_busy_at_done", i), 32'(bad), 32'h0);
        end
        // done is a single-cycle pulse when no new start follows.
        @(posedge clock); #1;
        chk("done_one_cycle", 32'(done), 32'h0);
        chk("idle_not_busy",  32'(busy), 32'h0);
        chk("result_held",    result,    32'hA5A5_A500);

        // Handshake: a start while busy is ignored.
        op = 2'b01; din = 32'h0000_00FF; amount = 5'd8; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; lat = 1;
        repeat (2) begin @(posedge clock); #1; lat++; end
        chk("busy_mid_shift", 32'(busy), 32'h1);
        chk("result_stable_mid_shift", result, 32'hA5A5_A500);
        op = 2'b00; din = 32'h0000_0001; amount = 5'd3; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; lat++;
        while (!done && lat < 100) begin @(posedge clock); #1; lat++; end
        $display("hs1 SRL FF by 8 with ignored start -> result=%08h lat=%0d", result, lat);
        chk("hs1_result",  result,    32'h0000_0000);
        chk("hs1_latency", 32'(lat),  32'd9);
        // Back-to-back start in the DONE cycle.
        run_op(2'b00, 32'h0000_0003, 5'd2, 1'b0, res, lat, bad);
        $display("hs2 SLL 3 by 2 from DONE -> result=%08h lat=%0d", res, lat);
        chk("hs2_result",  res,      32'h0000_000C);
        chk("hs2_latency", 32'(lat), 32'd3);
        @(posedge clock); #1;

        // Randomized ops with mid-shift input noise and ignored start pulses.
        for (int n = 0; n < 150; n++) begin
            ro = 2'($urandom);
            rd = $urandom;
            ra = 5'($urandom);
            run_op(ro, rd, ra, 1'b1, res, lat, bad);
            $display("rnd %0d op=%0d din=%08h amt=%0d -> result=%08h lat=%0d", n, ro, rd, ra, res, lat);
            chk($sformatf("rnd%0d_result", n), res, ref_shift(ro, rd, ra));
            chk($sformatf("rnd%0d_latency", n), 32'(lat), 32'(int'(ra) + 1));
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clock); #1;
            end
        end
        @(posedge clock); #1;

        // Reset mid-shift aborts with no done afterwards.
        op = 2'b00; din = 32'h0000_0001; amount = 5'd31; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        $display("reset mid-shift -> busy=%0d done=%0d result=%08h", busy, done, result);
        chk("abort_busy",   32'(busy), 32'h0);
        chk("abort_done",   32'(done), 32'h0);
        chk("abort_result", result,    32'h0);
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        dones = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (done || busy) dones++;
        end
        $display("after abort release: %0d active cycles", dones);
        chk("abort_no_done", 32'(dones), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Multi-cycle shift controller for the 32-bit shift datapath. It accepts a word, a shift amount and an operation code through a start/busy/done handshake, then performs one 1-bit shift per clock in an internal shift register. The block sits between the ALU issue logic and the result bus, and replaces wide barrel shifting with a sequenced serial shift.

Parameters:
WIDTH, 32, data width in bits
AMT_W, 5, shift-amount width; must satisfy 2**AMT_W == WIDTH

Ports:
clock  in  1  system clock, rising-edge active
reset  in  1  asynchronous, active-high reset
start  in  1  request pulse; sampled only when not busy
op  in  2  00=SLL, 01=SRL, 10=SRA, 11=ROR (see Optional Feature)
din  in  WIDTH  operand
amount  in  AMT_W  shift distance, 0..WIDTH-1
busy  out  1  high while a shift is in progress (SHIFT state)
done  out  1  one-cycle pulse, result valid
result  out  WIDTH  shifted word; held stable from done until the next accepted start

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, result=0; internal shift register, counter and op latch = 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: if start=1, latch din into the shift register, amount into cnt, and op into op_q.
  - amount==0: next state DONE.
  - Otherwise: next state SHIFT.
- SHIFT: busy=1. Each edge shifts by one bit according to op_q and decrements cnt.
  - SLL: shift left, fill 0.
  - SRL: shift right, fill 0.
  - SRA: shift right, fill with the current MSB.
  - ROR: shift right, LSB moves into MSB.
  - On the edge where cnt==1, the shift completes, cnt becomes 0 and next state is DONE.
- DONE: done=1 for exactly one cycle; result = shift register (registered, updated on entry to DONE).
  - start=1 in DONE: accepted exactly as in IDLE (back-to-back ops). Next state SHIFT or DONE; done is still high this cycle.
  - start=0: next state IDLE.
- Latency: the start-capture edge is E0. done is high in the cycle after edge E0+amount. amount=0 gives 1 cycle; amount=31 gives 32 cycles.
- start while busy=1: ignored, with no effect on state, counter or latched operands.
- din, op and amount are don't-care except on the accepting edge. Changes mid-shift have no effect.
- result is unchanged during SHIFT; it keeps the previous op's value until DONE.
- busy and done are never high together.
- Reset asserted mid-SHIFT aborts the operation immediately. After reset release the block is in IDLE and done is not generated for the aborted op.
- amount is unsigned. Because the width guarantees amount ≤ WIDTH-1, no saturation logic is needed.

Optional Feature:
Macro SHIFT_ROTATE_EN.
- Defined: op=11 performs rotate-right (ROR) as described above.
- Undefined: op=11 is decoded as SRL (zero fill) and no rotate wiring is synthesized. All other ops and the timing are identical.

Test Plan:
- Reset mid-shift: start SLL din=0x0000_0001 amount=31, assert reset after 10 cycles -> busy=0, done=0, result=0 immediately. No done pulse after release.
- Zero shift: start SRL din=0xDEAD_BEEF amount=0 -> done high the cycle after the start edge, result=0xDEAD_BEEF, busy never high.
- Logical ops: SLL 0x0000_0001 by 31 -> result=0x8000_0000 after 32 cycles. SRL 0x8000_0000 by 4 -> result=0x0800_0000, done 5 cycles after start.
- Arithmetic/rotate:
  - SRA 0x8000_0000 by 4 -> 0xF800_0000.
  - With SHIFT_ROTATE_EN, ROR 0x0000_0001 by 1 -> 0x8000_0000.
  - Without it, same stimulus -> 0x0000_0000.
- Handshake:
  - Pulse start (SLL 0x1 by 3) while busy during a SRL 0xFF by 8 -> ignored; result=0x0000_0000, single done.
  - Then start SLL 0x3 by 2 in the DONE cycle -> accepted; second done 3 cycles later, result=0x0000_000C.
